pipe_wb_stage: RTL and testbench
================================

Name: pipe_wb_stage

Overview:
- Write-back stage of the static pipeline CPU. It sits directly downstream of the MEM/WB pipeline register and consumes its W* outputs.
- Selects the register-file write data and owns the architectural state: the 32x32 general register file and the HI/LO register pair.
- Exposes read ports and write-back results for the ID stage and the forwarding logic.

Parameters:
- NREG, 32, number of general registers (address width fixed at 5).
- XLEN, 32, datapath width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- wena  in  1  stage write enable; 0 suppresses every architectural write
- Ww_rf  in  1  register-file write request
- Ww_hi  in  1  HI write request
- Ww_lo  in  1  LO write request
- Wrn  in  5  destination register number
- Wrfsource  in  3  register-file data select
- Whisource  in  2  HI data select
- Wlosource  in  2  LO data select
- Walu, Wa, Wb, Wdm, Wpc4, Wcounter, Wcp0, Whi, Wlo, Wmuler_hi, Wmuler_lo, Wq, Wr  in  32 each  data carried from MEM/WB
- ra1, ra2  in  5 each  ID-stage read addresses
- rd1, rd2  out  32 each  read data (combinational, write-through)
- hi_q, lo_q  out  32 each  current HI/LO values (write-through)
- wb_we  out  1  effective register-file write this cycle (forwarding)
- wb_rn  out  5  equals Wrn
- wb_data  out  32  selected write-back data (combinational)
- retired  out  32  count of cycles with wena=1

Behaviour:
- Reset, synchronous: on a rising clk with rst=1, all 32 registers, HI, LO and retired are cleared to 0. rst overrides any simultaneous write. After reset, rd1, rd2, hi_q and lo_q read 0.
- Register-file data select (Wrfsource):
  - 0 Walu
  - 1 Wdm
  - 2 Wpc4
  - 3 HI register value
  - 4 LO register value
  - 5 Wcounter
  - 6 Wcp0
  - 7 Wmuler_lo
- wb_data is purely combinational from the current inputs and register state.
- Codes 3 and 4 read the registered HI/LO values, not the write-through value. An mfhi in WB therefore sees HI as of the end of the previous cycle. This is correct because program order is preserved.
- HI next value (Whisource): 0 Wa (mthi), 1 Wmuler_hi (mult), 2 Wr (div remainder), 3 Whi (pass-through).
- LO next value (Wlosource): 0 Wa (mtlo), 1 Wmuler_lo, 2 Wq (div quotient), 3 Wlo.
- Write conditions:
  - Register file: wb_we = wena & Ww_rf & (Wrn != 0). On the rising edge, reg[Wrn] <= wb_data.
  - HI: written when wena & Ww_hi.
  - LO: written when wena & Ww_lo.
  - HI and LO may be written in the same cycle (mult/div), independently of the register-file write.
- Register 0 is hardwired: reads return 0 and writes are discarded.
- Read ports: rdN = 0 if raN == 0; otherwise wb_data if wb_we and raN == Wrn; otherwise reg[raN].
- Both read ports may hit the same address or the bypass simultaneously; each resolves independently.
- hi_q / lo_q: these return the next value when the corresponding write is active this cycle, otherwise the register. The EX stage therefore sees a same-cycle mthi/mult.
- wena=0 freezes all state (registers, HI, LO, retired). Combinational outputs still track the inputs, but wb_we is 0, so no bypass occurs.
- retired increments by 1 on each edge with wena=1 and rst=0, and wraps from 0xFFFFFFFF to 0.
- Latency:
  - Writes become visible in storage one edge later.
  - Bypassed reads see the value in the same cycle.
  - No multi-cycle operations.

Decomposition:
- pipe_defs_pkg holds:
  - RFSRC_ALU..RFSRC_MULLO (3-bit) constants
  - HLSRC_A, HLSRC_MUL, HLSRC_DIV, HLSRC_PASS (2-bit) constants
  - REG_ZERO = 5'd0
- One sub-module, pipe_regfile: 32x32 storage with 2 read ports, 1 write port, r0 hardwiring and write-through bypass.
- pipe_wb_stage instantiates pipe_regfile and holds the muxes, the HI/LO registers and the retired counter.

Test Plan:
- Reset: preload r5=0x1234 and HI=7, assert rst for 1 cycle -> rd1(ra1=5)=0, hi_q=0, lo_q=0, retired=0. A write issued during the rst cycle does not land.
- ALU write-back and bypass: Ww_rf=1, Wrn=8, Wrfsource=0, Walu=0xDEADBEEF, ra1=8 -> in the same cycle rd1=0xDEADBEEF and wb_we=1. Next cycle, with Ww_rf=0, rd1 is still 0xDEADBEEF.
- r0 protection: Ww_rf=1, Wrn=0, Walu=0xFFFFFFFF -> wb_we=0 and rd2(ra2=0)=0 afterwards.
- mult then mfhi/mflo:
  - Cycle 1: Ww_hi=Ww_lo=1, Whisource=Wlosource=1, Wmuler_hi=0x1, Wmuler_lo=0x2 -> hi_q=1 and lo_q=2 in the same cycle.
  - Cycle 2: Wrfsource=3, Wrn=9 -> r9=1.
  - Cycle 3: Wrfsource=4, Wrn=10 -> r10=2.
- div and mthi: Whisource=2, Wlosource=2, Wr=3, Wq=5 -> HI=3, LO=5. Then Whisource=0, Wa=0xAA, Ww_hi=1 only -> HI=0xAA, LO still 5.
- Stall freeze and counter wrap:
  - wena=0 with Ww_rf=1, Wrn=4, Walu=9 -> r4 unchanged, retired unchanged, wb_we=0.
  - Force retired to 0xFFFFFFFF via 2^32-1 enabled cycles (or a backdoor preload), then one cycle with wena=1 -> retired=0.

Source files
------------

// File: rtl/pipe_defs_pkg.sv
// Shared constants for the write-back stage: data-select codes, widths and
// the hardwired zero register number.
package pipe_defs_pkg;

    localparam int NREG_DEF = 32;
    localparam int XLEN_DEF = 32;
    localparam int RN_W     = 5;

    // Register-file write-data select codes.
    localparam logic [2:0] RFSRC_ALU     = 3'd0;
    localparam logic [2:0] RFSRC_DM      = 3'd1;
    localparam logic [2:0] RFSRC_PC4     = 3'd2;
    localparam logic [2:0] RFSRC_HI      = 3'd3;
    localparam logic [2:0] RFSRC_LO      = 3'd4;
    localparam logic [2:0] RFSRC_COUNTER = 3'd5;
    localparam logic [2:0] RFSRC_CP0     = 3'd6;
    localparam logic [2:0] RFSRC_MULLO   = 3'd7;

    // HI/LO next-value select codes.
    localparam logic [1:0] HLSRC_A    = 2'd0;
    localparam logic [1:0] HLSRC_MUL  = 2'd1;
    localparam logic [1:0] HLSRC_DIV  = 2'd2;
    localparam logic [1:0] HLSRC_PASS = 2'd3;

    localparam logic [RN_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_wb_stage_if.sv
// MEM/WB bundle consumed by the write-back stage. The MEM/WB register drives
// the master side, the write-back stage reads the slave side.
interface pipe_wb_stage_if #(
    parameter int XLEN = 32
);
    // No valid/ready pair: wena qualifies every request in the bundle, and a
    // cycle with wena=0 carries no architectural effect whatever else is set.
    logic            wena;
    logic            Ww_rf;
    logic            Ww_hi;
    logic            Ww_lo;
    logic [4:0]      Wrn;
    logic [2:0]      Wrfsource;
    logic [1:0]      Whisource;
    logic [1:0]      Wlosource;
    logic [XLEN-1:0] Walu;
    logic [XLEN-1:0] Wa;
    logic [XLEN-1:0] Wb;
    logic [XLEN-1:0] Wdm;
    logic [XLEN-1:0] Wpc4;
    logic [XLEN-1:0] Wcounter;
    logic [XLEN-1:0] Wcp0;
    logic [XLEN-1:0] Whi;
    logic [XLEN-1:0] Wlo;
    logic [XLEN-1:0] Wmuler_hi;
    logic [XLEN-1:0] Wmuler_lo;
    logic [XLEN-1:0] Wq;
    logic [XLEN-1:0] Wr;

    modport master (
        output wena, Ww_rf, Ww_hi, Ww_lo, Wrn, Wrfsource, Whisource, Wlosource,
        output Walu, Wa, Wb, Wdm, Wpc4, Wcounter, Wcp0, Whi, Wlo,
        output Wmuler_hi, Wmuler_lo, Wq, Wr
    );

    modport slave (
        input wena, Ww_rf, Ww_hi, Ww_lo, Wrn, Wrfsource, Whisource, Wlosource,
        input Walu, Wa, Wb, Wdm, Wpc4, Wcounter, Wcp0, Whi, Wlo,
        input Wmuler_hi, Wmuler_lo, Wq, Wr
    );

endinterface

// File: rtl/pipe_regfile.sv
// General register file: two combinational read ports with write-through
// bypass, one write port, register 0 hardwired to zero.
module pipe_regfile
    import pipe_defs_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [RN_W-1:0] wa_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [RN_W-1:0] ra1_i,
    input  logic [RN_W-1:0] ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o
);

    logic [XLEN-1:0] mem_q [NREG];
    logic            wr_en;

    // Entry 0 is never written, so its storage stays at the reset value.
    assign wr_en = we_i && (wa_i != REG_ZERO);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == REG_ZERO)           ? '0   :
                   (wr_en && (ra1_i == wa_i))    ? wd_i :
                                                   mem_q[ra1_i];

    assign rd2_o = (ra2_i == REG_ZERO)           ? '0   :
                   (wr_en && (ra2_i == wa_i))    ? wd_i :
                                                   mem_q[ra2_i];

endmodule

// File: rtl/pipe_wb_stage.sv
// Write-back stage: selects register-file write data, owns the register
// file, the HI/LO pair and the retired-cycle counter.
module pipe_wb_stage
    import pipe_defs_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pipe_wb_stage_if.slave  bus,
    input  logic [RN_W-1:0] ra1,
    input  logic [RN_W-1:0] ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic [XLEN-1:0] hi_q,
    output logic [XLEN-1:0] lo_q,
    output logic            wb_we,
    output logic [RN_W-1:0] wb_rn,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     retired
);

    logic [XLEN-1:0] hi_reg_q, hi_d;
    logic [XLEN-1:0] lo_reg_q, lo_d;
    logic [31:0]     retired_q, retired_d;
    logic [XLEN-1:0] hi_next, lo_next;
    logic            hi_we, lo_we;
    logic            unused_wb;

    // Wb travels with the bundle but no write-back source selects it.
    assign unused_wb = ^bus.Wb;

    // mfhi/mflo read the stored HI/LO, not this cycle's write-through value.
    always_comb begin
        wb_data = bus.Walu;
        unique case (bus.Wrfsource)
            RFSRC_ALU:     wb_data = bus.Walu;
            RFSRC_DM:      wb_data = bus.Wdm;
            RFSRC_PC4:     wb_data = bus.Wpc4;
            RFSRC_HI:      wb_data = hi_reg_q;
            RFSRC_LO:      wb_data = lo_reg_q;
            RFSRC_COUNTER: wb_data = bus.Wcounter;
            RFSRC_CP0:     wb_data = bus.Wcp0;
            RFSRC_MULLO:   wb_data = bus.Wmuler_lo;
            default:       wb_data = bus.Walu;
        endcase
    end

    always_comb begin
        hi_next = bus.Wa;
        unique case (bus.Whisource)
            HLSRC_A:    hi_next = bus.Wa;
            HLSRC_MUL:  hi_next = bus.Wmuler_hi;
            HLSRC_DIV:  hi_next = bus.Wr;
            HLSRC_PASS: hi_next = bus.Whi;
            default:    hi_next = bus.Wa;
        endcase
    end

    always_comb begin
        lo_next = bus.Wa;
        unique case (bus.Wlosource)
            HLSRC_A:    lo_next = bus.Wa;
            HLSRC_MUL:  lo_next = bus.Wmuler_lo;
            HLSRC_DIV:  lo_next = bus.Wq;
            HLSRC_PASS: lo_next = bus.Wlo;
            default:    lo_next = bus.Wa;
        endcase
    end

    assign wb_we = bus.wena && bus.Ww_rf && (bus.Wrn != REG_ZERO);
    assign wb_rn = bus.Wrn;
    assign hi_we = bus.wena && bus.Ww_hi;
    assign lo_we = bus.wena && bus.Ww_lo;

    always_comb begin
        hi_d      = hi_reg_q;
        lo_d      = lo_reg_q;
        retired_d = retired_q;
        if (hi_we) begin
            hi_d = hi_next;
        end
        if (lo_we) begin
            lo_d = lo_next;
        end
        if (bus.wena) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_reg_q  <= '0;
            lo_reg_q  <= '0;
            retired_q <= '0;
        end else begin
            hi_reg_q  <= hi_d;
            lo_reg_q  <= lo_d;
            retired_q <= retired_d;
        end
    end

    // EX sees a same-cycle mthi/mult through these write-through outputs.
    assign hi_q    = hi_we ? hi_next : hi_reg_q;
    assign lo_q    = lo_we ? lo_next : lo_reg_q;
    assign retired = retired_q;

    pipe_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .we_i  (wb_we),
        .wa_i  (bus.Wrn),
        .wd_i  (wb_data),
        .ra1_i (ra1),
        .ra2_i (ra2),
        .rd1_o (rd1),
        .rd2_o (rd2)
    );

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Bench for pipe_wb_stage: directed scenarios plus random traffic, all
// checked against an architectural model of the register file and HI/LO.
module tb_pipe_wb_stage;
    import pipe_defs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_wb_stage_if #(.XLEN(32)) bus ();

    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2, hi_q, lo_q, wb_data, retired;
    logic        wb_we;
    logic [4:0]  wb_rn;

    pipe_wb_stage dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ra1     (ra1),
        .ra2     (ra2),
        .rd1     (rd1),
        .rd2     (rd2),
        .hi_q    (hi_q),
        .lo_q    (lo_q),
        .wb_we   (wb_we),
        .wb_rn   (wb_rn),
        .wb_data (wb_data),
        .retired (retired)
    );

    // ---------------- architectural model ----------------
    logic [31:0] m_rf [32];
    logic [31:0] m_hi, m_lo, m_ret;
    logic [31:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] m_wb_data();
        logic [31:0] src [8];
        src[0] = bus.Walu;   src[1] = bus.Wdm;  src[2] = bus.Wpc4; src[3] = m_hi;
        src[4] = m_lo;       src[5] = bus.Wcounter; src[6] = bus.Wcp0; src[7] = bus.Wmuler_lo;
        return src[bus.Wrfsource];
    endfunction

    function automatic logic [31:0] m_hi_next();
        logic [31:0] src [4];
        src[0] = bus.Wa; src[1] = bus.Wmuler_hi; src[2] = bus.Wr; src[3] = bus.Whi;
        return src[bus.Whisource];
    endfunction

    function automatic logic [31:0] m_lo_next();
        logic [31:0] src [4];
        src[0] = bus.Wa; src[1] = bus.Wmuler_lo; src[2] = bus.Wq; src[3] = bus.Wlo;
        return src[bus.Wlosource];
    endfunction

    function automatic logic m_we();
        return bus.wena && bus.Ww_rf && (bus.Wrn != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (m_we() && ra == bus.Wrn) return m_wb_data();
        return m_rf[ra];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        bus.wena = 1'b0; bus.Ww_rf = 1'b0; bus.Ww_hi = 1'b0; bus.Ww_lo = 1'b0;
        bus.Wrn = 5'd0; bus.Wrfsource = 3'd0; bus.Whisource = 2'd0; bus.Wlosource = 2'd0;
        bus.Walu = '0; bus.Wa = '0; bus.Wb = '0; bus.Wdm = '0; bus.Wpc4 = '0;
        bus.Wcounter = '0; bus.Wcp0 = '0; bus.Whi = '0; bus.Wlo = '0;
        bus.Wmuler_hi = '0; bus.Wmuler_lo = '0; bus.Wq = '0; bus.Wr = '0;
        ra1 = 5'd0; ra2 = 5'd0;
    endtask

    task automatic drive_random();
        bus.wena = ($urandom_range(0, 9) < 8);
        bus.Ww_rf = $urandom_range(0, 1); bus.Ww_hi = ($urandom_range(0, 3) == 0);
        bus.Ww_lo = ($urandom_range(0, 3) == 0);
        bus.Wrn = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.Wrfsource = 3'($urandom_range(0, 7));
        bus.Whisource = 2'($urandom_range(0, 3)); bus.Wlosource = 2'($urandom_range(0, 3));
        bus.Walu = $urandom; bus.Wa = $urandom; bus.Wb = $urandom; bus.Wdm = $urandom;
        bus.Wpc4 = $urandom; bus.Wcounter = $urandom; bus.Wcp0 = $urandom;
        bus.Whi = $urandom; bus.Wlo = $urandom; bus.Wmuler_hi = $urandom;
        bus.Wmuler_lo = $urandom; bus.Wq = $urandom; bus.Wr = $urandom;
        ra1 = ($urandom_range(0, 2) == 0) ? bus.Wrn : 5'($urandom_range(0, 31));
        ra2 = ($urandom_range(0, 2) == 0) ? bus.Wrn : 5'($urandom_range(0, 31));
        rst = ($urandom_range(0, 99) == 0);
    endtask

    // Sample mid-cycle and score every output against the model.
    task automatic probe();
        @(negedge clk);
        exp_q.push_back(m_read(ra1));
        exp_q.push_back(m_read(ra2));
        exp_q.push_back(m_wb_data());
        exp_q.push_back({31'd0, m_we()});
        exp_q.push_back((bus.wena && bus.Ww_hi) ? m_hi_next() : m_hi);
        exp_q.push_back((bus.wena && bus.Ww_lo) ? m_lo_next() : m_lo);
        exp_q.push_back(m_ret);
        exp_q.push_back({27'd0, bus.Wrn});
        check_eq("rd1", rd1, exp_q.pop_front());
        check_eq("rd2", rd2, exp_q.pop_front());
        check_eq("wb_data", wb_data, exp_q.pop_front());
        check_eq("wb_we", {31'd0, wb_we}, exp_q.pop_front());
        check_eq("hi_q", hi_q, exp_q.pop_front());
        check_eq("lo_q", lo_q, exp_q.pop_front());
        check_eq("retired", retired, exp_q.pop_front());
        check_eq("wb_rn", {27'd0, wb_rn}, exp_q.pop_front());
    endtask

    // Clock edge, then advance the model with the inputs that were present.
    task automatic tick();
        logic [31:0] wbd, hin, lon;
        logic        we;
        @(posedge clk);
        wbd = m_wb_data(); hin = m_hi_next(); lon = m_lo_next(); we = m_we();
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
            m_hi = '0; m_lo = '0; m_ret = '0;
        end else if (bus.wena) begin
            if (we) m_rf[bus.Wrn] = wbd;
            if (bus.Ww_hi) m_hi = hin;
            if (bus.Ww_lo) m_lo = lon;
            m_ret = m_ret + 32'd1;
        end
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ret_before;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Reset: preload r5 and HI, then a reset cycle carrying a write.
        idle(); bus.wena = 1; bus.Ww_rf = 1; bus.Wrn = 5'd5; bus.Walu = 32'h1234;
        probe(); tick();
        idle(); bus.wena = 1; bus.Ww_hi = 1; bus.Whisource = HLSRC_A; bus.Wa = 32'd7;
        probe(); tick();
        idle(); ra1 = 5'd5;
        probe(); check_eq("pre_r5", rd1, 32'h1234); check_eq("pre_hi", hi_q, 32'd7); tick();
        idle(); rst = 1; bus.wena = 1; bus.Ww_rf = 1; bus.Wrn = 5'd6; bus.Walu = 32'h55;
        probe(); tick();
        rst = 0; idle(); ra1 = 5'd5; ra2 = 5'd6;
        probe();
        check_eq("rst_r5", rd1, 32'd0); check_eq("rst_r6", rd2, 32'd0);
        check_eq("rst_hi", hi_q, 32'd0); check_eq("rst_lo", lo_q, 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        tick();

        // ALU write-back with same-cycle bypass, then stored value.
        idle(); bus.wena = 1; bus.Ww_rf = 1; bus.Wrn = 5'd8; bus.Walu = 32'hDEADBEEF; ra1 = 5'd8;
        probe(); check_eq("byp_rd1", rd1, 32'hDEADBEEF); check_eq("byp_we", {31'd0, wb_we}, 32'd1);
        tick();
        idle(); bus.wena = 1; ra1 = 5'd8;
        probe(); check_eq("stored_r8", rd1, 32'hDEADBEEF); tick();

        // r0 protection.
        idle(); bus.wena = 1; bus.Ww_rf = 1; bus.Wrn = 5'd0; bus.Walu = 32'hFFFFFFFF;
        probe(); check_eq("r0_we", {31'd0, wb_we}, 32'd0); tick();
        idle(); ra2 = 5'd0;
        probe(); check_eq("r0_rd2", rd2, 32'd0); tick();

        // mult, then mfhi / mflo.
        idle(); bus.wena = 1; bus.Ww_hi = 1; bus.Ww_lo = 1;
        bus.Whisource = HLSRC_MUL; bus.Wlosource = HLSRC_MUL;
        bus.Wmuler_hi = 32'h1; bus.Wmuler_lo = 32'h2;
        probe(); check_eq("mult_hi", hi_q, 32'd1); check_eq("mult_lo", lo_q, 32'd2); tick();
        idle(); bus.wena = 1; bus.Ww_rf = 1; bus.Wrn = 5'd9; bus.Wrfsource = RFSRC_HI;
        probe(); tick();
        idle(); bus.wena = 1; bus.Ww_rf = 1; bus.Wrn = 5'd10; bus.Wrfsource = RFSRC_LO;
        probe(); tick();
        idle(); ra1 = 5'd9; ra2 = 5'd10;
        probe(); check_eq("mfhi_r9", rd1, 32'd1); check_eq("mflo_r10", rd2, 32'd2); tick();

        // div, then mthi alone.
        idle(); bus.wena = 1; bus.Ww_hi = 1; bus.Ww_lo = 1;
        bus.Whisource = HLSRC_DIV; bus.Wlosource = HLSRC_DIV; bus.Wr = 32'd3; bus.Wq = 32'd5;
        probe(); tick();
        idle(); bus.wena = 1; bus.Ww_hi = 1; bus.Whisource = HLSRC_A; bus.Wa = 32'hAA;
        probe(); tick();
        idle();
        probe(); check_eq("mthi_hi", hi_q, 32'hAA); check_eq("div_lo", lo_q, 32'd5); tick();

        // Stall freezes state.
        ret_before = m_ret;
        idle(); bus.wena = 0; bus.Ww_rf = 1; bus.Wrn = 5'd4; bus.Walu = 32'd9; ra1 = 5'd4;
        probe(); check_eq("stall_we", {31'd0, wb_we}, 32'd0); check_eq("stall_nobyp", rd1, 32'd0);
        tick();
        idle(); ra1 = 5'd4;
        probe(); check_eq("stall_r4", rd1, 32'd0); check_eq("stall_ret", retired, ret_before);
        tick();

        // Counter wrap via backdoor preload.
        force dut.retired_q = 32'hFFFFFFFF;
        #1 release dut.retired_q;
        m_ret = 32'hFFFFFFFF;
        idle(); bus.wena = 1;
        probe(); check_eq("ret_preload", retired, 32'hFFFFFFFF); tick();
        idle();
        probe(); check_eq("ret_wrap", retired, 32'd0); tick();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            drive_random();
            probe();
            tick();
        end
        rst = 0; idle();
        probe();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
